// File: rtl/ps2_key_decoder_if.sv
// PS/2 key decoder bus.
// Groups the raw PS/2 device lines with the decoded key event outputs.
//   master : the decoder. It receives ps2_clk/ps2_data and drives the key outputs.
//   slave  : the consumer side. It drives the PS/2 lines and receives the key outputs.
interface ps2_key_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic [7:0] asc_num;
  logic       key_released;
  logic       key_ext;
  logic       key_valid;
  logic       frame_err;

  modport master (
    input  ps2_clk, ps2_data,
    output scan_code, asc_num, key_released, key_ext, key_valid, frame_err
  );

  modport slave (
    output ps2_clk, ps2_data,
    input  scan_code, asc_num, key_released, key_ext, key_valid, frame_err
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: deframes 11-bit PS/2 frames and interprets the E0/F0 prefixes.
// It reports the last make code together with its ASCII value.
// Optional macro PS2_SHIFT_EN: tracks the left/right shift keys (12/59) and maps make
// codes to their shifted characters while shift is held.
// Ports:
//   clk  : system clock
//   clrn : asynchronous active-low reset
//   bus  : ps2_key_decoder_if.master
//          inputs : ps2_clk, ps2_data (raw and asynchronous)
//          outputs: scan_code, asc_num, key_released, key_ext,
//                   key_valid (one-cycle pulse), frame_err (one-cycle pulse)
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input logic              clk,
  input logic              clrn,
  ps2_key_decoder_if.master bus
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBreak, StExt, StExtBreak} state_e;

  // Lowercase / unshifted set-2 lookup.
  function automatic logic [7:0] lookup_lower(input logic [7:0] code);
    logic [7:0] a;
    unique case (code)
      8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
      8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
      8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
      8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
      8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
      8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
      8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
      8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
      8'h3E: a = 8'h38;  8'h46: a = 8'h39;
      8'h29: a = 8'h20;  8'h5A: a = 8'h0D;  8'h66: a = 8'h08;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

`ifdef PS2_SHIFT_EN
  // Shifted lookup: uppercase letters and US-layout digit symbols.
  function automatic logic [7:0] lookup_shift(input logic [7:0] code);
    logic [7:0] l;
    logic [7:0] a;
    l = lookup_lower(code);
    unique case (code)
      8'h45: a = 8'h29;  8'h16: a = 8'h21;  8'h1E: a = 8'h40;  8'h26: a = 8'h23;
      8'h25: a = 8'h24;  8'h2E: a = 8'h25;  8'h36: a = 8'h5E;  8'h3D: a = 8'h26;
      8'h3E: a = 8'h2A;  8'h46: a = 8'h28;
      default: a = (l >= 8'h61 && l <= 8'h7A) ? (l - 8'h20) : l;
    endcase
    return a;
  endfunction
`endif

  // Two-flop synchronisers plus an edge-detect history flop.
  logic [1:0] clk_sync, data_sync;
  logic       clk_prev;
  logic       fall, data_bit;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], bus.ps2_clk};
      data_sync <= {data_sync[0], bus.ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign fall     = clk_prev & ~clk_sync[1];
  assign data_bit = data_sync[1];

  // Deframer.
  logic [3:0]    bit_cnt, bit_idx;
  logic [9:0]    shreg;
  logic [TW-1:0] tmo_cnt;
  logic          timeout, frame_good;
  logic          byte_ok, frame_err_q;
  logic [7:0]    rx_byte;

  assign timeout = (bit_cnt != 4'd0) && (tmo_cnt == TmoLast);
  // A falling edge that coincides with a timeout starts a new frame at bit0.
  assign bit_idx = timeout ? 4'd0 : bit_cnt;
  // The incoming bit is the stop bit. Data plus parity must have odd parity.
  assign frame_good = ~shreg[0] & data_bit & (^shreg[9:1]);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bit_cnt     <= 4'd0;
      shreg       <= '0;
      tmo_cnt     <= '0;
      byte_ok     <= 1'b0;
      frame_err_q <= 1'b0;
      rx_byte     <= 8'h00;
    end else begin
      byte_ok     <= 1'b0;
      frame_err_q <= 1'b0;
      if (fall) begin
        tmo_cnt <= '0;
        if (bit_idx == 4'd10) begin
          bit_cnt     <= 4'd0;
          byte_ok     <= frame_good;
          frame_err_q <= ~frame_good;
          rx_byte     <= shreg[8:1];
        end else begin
          shreg[bit_idx] <= data_bit;
          bit_cnt        <= bit_idx + 4'd1;
        end
      end else if (timeout) begin
        bit_cnt <= 4'd0;
        tmo_cnt <= '0;
      end else if (bit_cnt != 4'd0) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  // Protocol FSM with registered outputs.
  state_e     state;
  logic [7:0] scan_q, asc_q, make_asc;
  logic       released_q, ext_q, valid_q;
  logic       is_shift;

  assign is_shift = (rx_byte == 8'h12) || (rx_byte == 8'h59);

`ifdef PS2_SHIFT_EN
  logic shift_held;
  assign make_asc = shift_held ? lookup_shift(rx_byte) : lookup_lower(rx_byte);
`else
  assign make_asc = lookup_lower(rx_byte);
`endif

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= StIdle;
      scan_q     <= 8'h00;
      asc_q      <= 8'h00;
      released_q <= 1'b1;
      ext_q      <= 1'b0;
      valid_q    <= 1'b0;
`ifdef PS2_SHIFT_EN
      shift_held <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      if (frame_err_q) begin
        state <= StIdle;
      end else if (byte_ok) begin
        unique case (state)
          StIdle: begin
            if (rx_byte == 8'hF0) begin
              state <= StBreak;
            end else if (rx_byte == 8'hE0) begin
              state <= StExt;
            end else begin
              scan_q     <= rx_byte;
              asc_q      <= make_asc;
              ext_q      <= 1'b0;
              released_q <= 1'b0;
              valid_q    <= 1'b1;
`ifdef PS2_SHIFT_EN
              if (is_shift) shift_held <= 1'b1;
`endif
            end
          end
          StBreak: begin
            released_q <= 1'b1;
            state      <= StIdle;
`ifdef PS2_SHIFT_EN
            if (is_shift) shift_held <= 1'b0;
`endif
          end
          StExt: begin
            if (rx_byte == 8'hF0) begin
              state <= StExtBreak;
            end else begin
              scan_q     <= rx_byte;
              asc_q      <= 8'h00;
              ext_q      <= 1'b1;
              released_q <= 1'b0;
              valid_q    <= 1'b1;
              state      <= StIdle;
            end
          end
          StExtBreak: begin
            released_q <= 1'b1;
            state      <= StIdle;
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

`ifndef PS2_SHIFT_EN
  logic unused_shift;
  assign unused_shift = is_shift;
`endif

  assign bus.scan_code    = scan_q;
  assign bus.asc_num      = asc_q;
  assign bus.key_released = released_q;
  assign bus.key_ext      = ext_q;
  assign bus.key_valid    = valid_q;
  assign bus.frame_err    = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder. It drives PS/2 frames and uses a scoreboard of expected
// make events that is checked whenever key_valid pulses.
module tb_ps2_key_decoder;

  localparam int unsigned Tmo  = 300;
  localparam int unsigned Half = 10;
  localparam int unsigned Gap  = 20;

  typedef struct packed {
    logic [7:0] scan;
    logic [7:0] asc;
    logic       ext;
  } exp_t;

  logic clk;
  logic clrn;
  ps2_key_decoder_if bus ();

  ps2_key_decoder #(.TIMEOUT_CYCLES(Tmo)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   valid_cnt = 0;
  int   err_cnt = 0;
  int   pushed = 0;
  exp_t sb[$];
  logic prev_valid = 1'b0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] scan, input logic [7:0] asc, input logic ext);
    exp_t e;
    e.scan = scan;
    e.asc  = asc;
    e.ext  = ext;
    sb.push_back(e);
    pushed++;
  endtask

  // Monitor: every key_valid pulse must match the oldest expected make event.
  always @(negedge clk) begin
    if (bus.key_valid === 1'b1) begin
      exp_t e;
      valid_cnt++;
      check("valid_one_cycle", {7'b0, prev_valid}, 8'h00);
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_valid: observed scan %h expected no event", bus.scan_code);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_scan", bus.scan_code, e.scan);
        check("sb_asc", bus.asc_num, e.asc);
        check("sb_ext", {7'b0, bus.key_ext}, {7'b0, e.ext});
      end
    end
    if (bus.frame_err === 1'b1) err_cnt++;
    prev_valid = bus.key_valid;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_bit(input logic b);
    bus.ps2_data = b;
    wait_clk(Half);
    bus.ps2_clk = 1'b0;
    wait_clk(Half);
    bus.ps2_clk = 1'b1;
  endtask

  // Sends the first nbits of a frame carrying byte b. bad flips the parity bit.
  task automatic send_bits(input logic [7:0] b, input logic bad, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(bits[i]);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad);
    send_bits(b, bad, 11);
    wait_clk(Gap);
  endtask

  task automatic check_reset_vals(input string tag);
    @(negedge clk);
    check({tag, "_scan"}, bus.scan_code, 8'h00);
    check({tag, "_asc"}, bus.asc_num, 8'h00);
    check({tag, "_rel"}, {7'b0, bus.key_released}, 8'h01);
    check({tag, "_ext"}, {7'b0, bus.key_ext}, 8'h00);
    check({tag, "_valid"}, {7'b0, bus.key_valid}, 8'h00);
    check({tag, "_ferr"}, {7'b0, bus.frame_err}, 8'h00);
  endtask

  task automatic check_outs(input string tag, input logic [7:0] scan, input logic [7:0] asc,
                            input logic rel, input logic ext);
    @(negedge clk);
    check({tag, "_scan"}, bus.scan_code, scan);
    check({tag, "_asc"}, bus.asc_num, asc);
    check({tag, "_rel"}, {7'b0, bus.key_released}, {7'b0, rel});
    check({tag, "_ext"}, {7'b0, bus.key_ext}, {7'b0, ext});
  endtask

  initial begin
    clrn         = 1'b0;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    wait_clk(4);
    check_reset_vals("reset");
    clrn = 1'b1;
    wait_clk(5);

    // Single make.
    push(8'h1C, 8'h61, 1'b0);
    send_frame(8'h1C, 1'b0);
    check_outs("make_1c", 8'h1C, 8'h61, 1'b0, 1'b0);
    check("make_1c_vcnt", 8'(valid_cnt), 8'd1);

    // Break of the same key.
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    check_outs("break_1c", 8'h1C, 8'h61, 1'b1, 1'b0);
    check("break_1c_vcnt", 8'(valid_cnt), 8'd1);

    // Parity error drops the byte and leaves the outputs unchanged.
    send_frame(8'h1C, 1'b1);
    check("perr_ferr_cnt", 8'(err_cnt), 8'd1);
    check_outs("perr_hold", 8'h1C, 8'h61, 1'b1, 1'b0);
    check("perr_vcnt", 8'(valid_cnt), 8'd1);
    push(8'h16, 8'h31, 1'b0);
    send_frame(8'h16, 1'b0);
    check_outs("after_perr", 8'h16, 8'h31, 1'b0, 1'b0);

    // Extended make, then extended break.
    push(8'h75, 8'h00, 1'b1);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    check_outs("ext_make", 8'h75, 8'h00, 1'b0, 1'b1);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    check_outs("ext_break", 8'h75, 8'h00, 1'b1, 1'b1);
    check("ext_vcnt", 8'(valid_cnt), 8'd3);

    // Partial frame abandoned by the timeout, then a clean frame.
    send_bits(8'h29, 1'b0, 5);
    wait_clk(Tmo + 10);
    push(8'h29, 8'h20, 1'b0);
    send_frame(8'h29, 1'b0);
    check_outs("tmo_space", 8'h29, 8'h20, 1'b0, 1'b0);
    check("tmo_ferr_cnt", 8'(err_cnt), 8'd1);

    // Typematic repeat.
    push(8'h1C, 8'h61, 1'b0);
    push(8'h1C, 8'h61, 1'b0);
    send_frame(8'h1C, 1'b0);
    send_frame(8'h1C, 1'b0);
    check("typematic_vcnt", 8'(valid_cnt), 8'd6);

    // Reset in the middle of a frame.
    send_bits(8'h5A, 1'b0, 5);
    clrn = 1'b0;
    wait_clk(3);
    check_reset_vals("midreset");
    clrn = 1'b1;
    wait_clk(5);
    push(8'h1A, 8'h7A, 1'b0);
    send_frame(8'h1A, 1'b0);
    check_outs("post_reset", 8'h1A, 8'h7A, 1'b0, 1'b0);
    check("post_reset_ferr_cnt", 8'(err_cnt), 8'd1);

    // Shift handling.
    push(8'h12, 8'h00, 1'b0);
    send_frame(8'h12, 1'b0);
`ifdef PS2_SHIFT_EN
    push(8'h1C, 8'h41, 1'b0);
    send_frame(8'h1C, 1'b0);
    check_outs("shift_a", 8'h1C, 8'h41, 1'b0, 1'b0);
    push(8'h16, 8'h21, 1'b0);
    send_frame(8'h16, 1'b0);
    check_outs("shift_1", 8'h16, 8'h21, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h12, 1'b0);
    push(8'h1C, 8'h61, 1'b0);
    send_frame(8'h1C, 1'b0);
    check_outs("unshift_a", 8'h1C, 8'h61, 1'b0, 1'b0);
`else
    push(8'h1C, 8'h61, 1'b0);
    send_frame(8'h1C, 1'b0);
    check_outs("noshift_a", 8'h1C, 8'h61, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h12, 1'b0);
`endif

    wait_clk(10);
    check("sb_drained", 8'(sb.size()), 8'd0);
    check("valid_total", 8'(valid_cnt), 8'(pushed));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
